chinx_ifetch: RTL and testbench

Instruction fetch unit for the chinx core. It is the consumer of the program counter: it walks the fetch address, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small in-order FIFO for decode. A redirect from the branch/exception path flushes the buffer, discards stale in-flight responses and restarts fetch at the new address.

---
 rtl/chinx_pkg.sv | 14 +
 rtl/chinx_ifetch_fifo.sv | 73 +++++++
 rtl/chinx_ifetch.sv | 135 +++++++++++++
 tb/tb_chinx_ifetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/chinx_pkg.sv
// Shared constants and types for the chinx instruction fetch path.
package chinx_pkg;

   localparam int unsigned CHINX_ADDR_WIDTH = 32;
   localparam int unsigned CHINX_INST_WIDTH = 32;
   localparam logic [CHINX_ADDR_WIDTH-1:0] CHINX_RESET_PC = '0;

   // One buffered fetch result: the instruction word and the address it came from.
   typedef struct packed {
      logic [CHINX_INST_WIDTH-1:0] inst;
      logic [CHINX_ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/chinx_ifetch_fifo.sv
// Synchronous in-order FIFO with push, pop, flush and an occupancy count.
// The head reads as zero while the FIFO is empty.
module chinx_ifetch_fifo
   import chinx_pkg::*;
#(
   parameter int unsigned WIDTH = CHINX_INST_WIDTH + CHINX_ADDR_WIDTH,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && (cnt_q != '0);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign valid_o = (cnt_q != '0);
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = cnt_q;

endmodule

// File: rtl/chinx_ifetch.sv
// Instruction fetch: walks the fetch PC, issues word reads to instruction memory
// and buffers responses for decode; a redirect flushes and restarts fetch.
module chinx_ifetch
   import chinx_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CHINX_ADDR_WIDTH,
   parameter int unsigned INST_WIDTH = CHINX_INST_WIDTH,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(CHINX_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [INST_WIDTH-1:0] imem_rdata_i,
   output logic                  inst_valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_pc_o,
   input  logic                  inst_ready_i
);

   // Handshakes: a memory request transfers on imem_req_o && imem_gnt_i, and once
   // raised req/addr hold until granted; each grant is answered by exactly one
   // in-order imem_rvalid_i pulse at least a cycle later. Decode takes the head
   // on inst_valid_o && inst_ready_i; inst_valid_o never depends on inst_ready_i.
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW:0] DEPTH_W = CW1'(FIFO_DEPTH);

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic                  pend_q, pend_d;
   logic                  pend_stale_q, pend_stale_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         stale_q, stale_d;
   logic [CW-1:0]         fifo_cnt, tag_cnt;
   logic [CW:0]           occupancy;
   logic                  grant, drop, push, pop, tag_valid;
   logic [ADDR_WIDTH-1:0] tag_pc;
   entry_t                push_entry, head_entry;

   always_comb begin
      occupancy     = {1'b0, fifo_cnt} + {1'b0, outstanding_q};
      imem_req_o    = !rst && (pend_q || (occupancy < DEPTH_W));
      imem_addr_o   = pend_q ? pend_addr_q : fetch_pc_q;
      grant         = imem_req_o && imem_gnt_i;
      drop          = imem_rvalid_i && (stale_q != '0);
      push          = imem_rvalid_i && !drop && !redirect_i;
      pop           = inst_valid_o && inst_ready_i && !redirect_i;
      push_entry    = '{inst: imem_rdata_i, pc: tag_pc};
      outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
      pend_d        = imem_req_o && !imem_gnt_i;
      pend_addr_d   = imem_addr_o;
      // A request caught ungranted by a redirect is remembered as stale until granted.
      pend_stale_d  = pend_d && (pend_stale_q || redirect_i);
      stale_d       = stale_q - CW'(drop) + CW'(grant && pend_stale_q);
      fetch_pc_d    = fetch_pc_q;
      if (grant && !pend_stale_q) begin
         fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i & ~ADDR_WIDTH'(3);
         stale_d    = outstanding_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         pend_addr_q   <= RESET_PC;
         pend_q        <= 1'b0;
         pend_stale_q  <= 1'b0;
         outstanding_q <= '0;
         stale_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         pend_addr_q   <= pend_addr_d;
         pend_q        <= pend_d;
         pend_stale_q  <= pend_stale_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
      end
   end

   // Addresses of granted requests, consumed one per response, stale or not.
   chinx_ifetch_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (1'b0),
      .push_i  (grant),
      .data_i  (imem_addr_o),
      .pop_i   (imem_rvalid_i),
      .valid_o (tag_valid),
      .data_o  (tag_pc),
      .count_o (tag_cnt)
   );

   chinx_ifetch_fifo #(
      .WIDTH (INST_WIDTH + ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_inst_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .valid_o (inst_valid_o),
      .data_o  (head_entry),
      .count_o (fifo_cnt)
   );

   assign inst_o    = head_entry.inst;
   assign inst_pc_o = head_entry.pc;

   a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid_i |-> (outstanding_q != '0 && tag_valid));
   a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
      tag_cnt == outstanding_q);
   a_stale_bounded: assert property (@(posedge clk) disable iff (rst)
      stale_q <= outstanding_q);

endmodule

// File: tb/tb_chinx_ifetch.sv
// Randomized bench for chinx_ifetch against a queue-based model of fetch,
// in-flight requests and the instruction buffer.
module tb_chinx_ifetch;
   import chinx_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i = 1'b0;

   chinx_ifetch #(
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } flight_t;

   flight_t     fl_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_pend_addr = RST_PC;
   bit          m_pend = 1'b0;
   bit          m_pend_stale = 1'b0;
   bit          m_req_v;
   logic [31:0] m_addr_v;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_req();
      return !rst && (m_pend || ((exp_q.size() + fl_q.size()) < DEPTH));
   endfunction

   function automatic logic [31:0] model_addr();
      return m_pend ? m_pend_addr : m_pc;
   endfunction

   task automatic compare();
      fetch_entry_t e;
      if (rst) begin
         chk("rst_req", 64'(imem_req_o), 64'(0));
         chk("rst_addr", 64'(imem_addr_o), 64'(RST_PC));
         chk("rst_valid", 64'(inst_valid_o), 64'(0));
         chk("rst_inst", 64'(inst_o), 64'(0));
         chk("rst_pc", 64'(inst_pc_o), 64'(0));
      end else begin
         chk("req", 64'(imem_req_o), 64'(model_req()));
         if (model_req()) chk("addr", 64'(imem_addr_o), 64'(model_addr()));
         chk("valid", 64'(inst_valid_o), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            e = fetch_entry_t'(exp_q[0]);
            chk("inst", 64'(inst_o), 64'(e.inst));
            chk("inst_pc", 64'(inst_pc_o), 64'(e.pc));
         end
      end
   endtask

   // Apply the spec's rules to the cycle that just ended at the clock edge.
   task automatic update_model();
      bit          grant, valid_pre, new_pend, do_push;
      flight_t     f;
      logic [63:0] ent;
      do_push = 1'b0;
      ent     = '0;
      if (rst) begin
         exp_q.delete();
         fl_q.delete();
         m_pc         = RST_PC;
         m_pend_addr  = RST_PC;
         m_pend       = 1'b0;
         m_pend_stale = 1'b0;
      end else begin
         grant     = m_req_v && imem_gnt_i;
         valid_pre = (exp_q.size() != 0);
         if (imem_rvalid_i) begin
            f = fl_q.pop_front();
            if (!f.stale && !redirect_i) begin
               do_push = 1'b1;
               ent     = {imem_rdata_i, f.addr};
            end
         end
         if (valid_pre && inst_ready_i && !redirect_i) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(ent);
         if (grant) begin
            f.addr  = m_addr_v;
            f.stale = m_pend_stale;
            fl_q.push_back(f);
            if (!m_pend_stale) m_pc = m_pc + 32'd4;
         end
         new_pend     = m_req_v && !imem_gnt_i;
         m_pend_stale = new_pend && (m_pend_stale || redirect_i);
         m_pend       = new_pend;
         m_pend_addr  = m_addr_v;
         if (redirect_i) begin
            exp_q.delete();
            foreach (fl_q[i]) fl_q[i].stale = 1'b1;
            m_pc = {redirect_pc_i[31:2], 2'b00};
         end
      end
   endtask

   // One clock: drive inputs (percent probabilities), advance, update model, check.
   task automatic step(input int g, input int r, input int y, input int d);
      logic [31:0] pc_pick;
      imem_gnt_i    = ($urandom_range(99) < g);
      imem_rvalid_i = !rst && (fl_q.size() != 0) && ($urandom_range(99) < r);
      imem_rdata_i  = $urandom();
      inst_ready_i  = ($urandom_range(99) < y);
      case ($urandom_range(2))
         0:       pc_pick = $urandom();
         1:       pc_pick = 32'hFFFF_FFF0 | $urandom_range(15);
         default: pc_pick = $urandom_range(255);
      endcase
      redirect_i    = !rst && (force_redir || ($urandom_range(99) < d));
      redirect_pc_i = force_redir ? force_pc : pc_pick;
      force_redir   = 1'b0;
      m_req_v       = model_req();
      m_addr_v      = model_addr();
      @(posedge clk);
      update_model();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) step(0, 0, 0, 0);
      rst = 1'b0;
      #1;
      compare();
   endtask

   task automatic redirect_to(input logic [31:0] pc, input int g, input int r, input int y);
      force_redir = 1'b1;
      force_pc    = pc;
      step(g, r, y, 0);
   endtask

   initial begin
      @(negedge clk);
      // Streaming from reset: addresses 0,4,8,C at one per cycle.
      do_reset(2);
      repeat (10) step(100, 100, 100, 0);

      // Decode stalled: four grants fill the buffer, then fetch resumes at 0x10.
      do_reset(1);
      repeat (10) step(100, 100, 0, 0);
      chk("stall_req", 64'(imem_req_o), 64'(0));
      chk("stall_addr", 64'(imem_addr_o), 64'(32'h10));
      repeat (6) step(100, 100, 100, 0);

      // Grant withheld: request and address hold.
      do_reset(1);
      repeat (2) step(100, 100, 100, 0);
      repeat (3) step(0, 100, 100, 0);
      repeat (4) step(100, 100, 100, 0);

      // Two requests outstanding when redirected to 0x103.
      do_reset(1);
      repeat (2) step(100, 0, 100, 0);
      redirect_to(32'h0000_0103, 0, 0, 100);
      repeat (2) step(0, 0, 100, 0);
      repeat (8) step(100, 100, 100, 0);

      // Redirect coinciding with a response and a pop.
      repeat (4) step(100, 100, 100, 0);
      redirect_to(32'h0000_0040, 100, 100, 100);
      repeat (4) step(100, 100, 100, 0);

      // Fetch address wraps past the top of the address space.
      redirect_to(32'hFFFF_FFFD, 100, 100, 100);
      repeat (6) step(100, 100, 100, 0);

      repeat (3000) step(70, 60, 60, 4);
      do_reset(1);
      repeat (2000) step(40, 40, 80, 8);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
